// File: rtl/pdm_sample_interp.sv
`default_nettype none
// ============================================================================
//  Module      : pdm_sample_interp
//  Description : PCM sample FIFO feeding a PDM DAC. Releases one sample per
//                2^INTERP_SHIFT clocks and linearly ramps between samples.
//  Revision    : 1.0 - initial release
// ============================================================================
module pdm_sample_interp #(
    parameter int WIDTH        = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int INTERP_SHIFT = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              sample_out,
    output logic                          tick,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int                    c_AW         = $clog2(FIFO_DEPTH);
    localparam int                    c_ACC_W      = WIDTH + INTERP_SHIFT + 1;
    localparam logic [c_AW:0]         c_DEPTH      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [INTERP_SHIFT-1:0] c_PHASE_LAST = '1;

    logic [WIDTH-1:0]          r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]           r_wr_ptr;
    logic [c_AW-1:0]           r_rd_ptr;
    logic [c_AW:0]             r_count;
    logic [INTERP_SHIFT-1:0]   r_phase;
    logic [WIDTH-1:0]          r_target;
    logic signed [WIDTH:0]     r_delta;
    logic signed [c_ACC_W-1:0] r_acc;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [WIDTH-1:0]          w_head;
    logic signed [WIDTH:0]     w_new_delta;
    logic signed [c_ACC_W-1:0] w_target_aligned;
    logic signed [c_ACC_W-1:0] w_delta_ext;

    assign w_full   = (r_count == c_DEPTH);
    assign w_empty  = (r_count == '0);
    assign w_push   = in_valid && !w_full;
    assign w_pop    = tick && !w_empty;
    assign w_head   = r_mem[r_rd_ptr];

    assign w_new_delta      = $signed({1'b0, w_head}) - $signed({1'b0, r_target});
    assign w_target_aligned = {1'b0, r_target, {INTERP_SHIFT{1'b0}}};
    assign w_delta_ext      = {{INTERP_SHIFT{r_delta[WIDTH]}}, r_delta};

    assign tick       = (r_phase == c_PHASE_LAST);
    assign underrun   = tick && w_empty;
    assign in_ready   = !w_full;
    assign fifo_level = r_count;
    assign sample_out = r_acc[WIDTH+INTERP_SHIFT-1:INTERP_SHIFT];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Each tick re-seeds acc from the exact target so rounding never accumulates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase  <= '0;
            r_target <= '0;
            r_delta  <= '0;
            r_acc    <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
            if (tick) begin
                r_acc <= w_target_aligned;
                if (w_empty) begin
                    r_delta <= '0;
                end else begin
                    r_delta  <= w_new_delta;
                    r_target <= w_head;
                end
            end else begin
                r_acc <= r_acc + w_delta_ext;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_sample_interp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pdm_sample_interp
//  Description : Self-checking bench for pdm_sample_interp against a
//                queue-based reference of the sample stream and ramp formula.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pdm_sample_interp;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int SHIFT = 2;
    localparam int N     = 1 << SHIFT;

    logic             clk      = 1'b0;
    logic             reset    = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data  = '0;
    logic             in_ready;
    logic [WIDTH-1:0] sample_out;
    logic             tick;
    logic             underrun;
    logic [2:0]       fifo_level;

    always #5 clk = ~clk;

    pdm_sample_interp #(
        .WIDTH        (WIDTH),
        .FIFO_DEPTH   (DEPTH),
        .INTERP_SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sample_out (sample_out),
        .tick       (tick),
        .underrun   (underrun),
        .fifo_level (fifo_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: stored samples, cycles since reset, and the current ramp
    // (start value, target value, cycles elapsed since the last tick edge).
    int q[$];
    int m_phase = 0;
    int m_s     = 0;
    int m_t     = 0;
    int m_k     = 0;
    bit m_live  = 1'b0;

    int exp1[25] = '{0, 0, 0, 0, 0, 25, 50, 75, 100, 100, 100, 100,
                     100, 75, 50, 25, 0, 0, 1, 2, 3, 2, 2, 1, 1};
    int vals1[5] = '{100, 100, 0, 3, 1};
    int vals5[4] = '{255, 10, 20, 30};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int exp_sample();
        return (m_s * N + m_k * (m_t - m_s)) / N;
    endfunction

    task automatic model_step();
        bit tk;
        bit rdy;
        if (reset) begin
            q.delete();
            m_phase = 0;
            m_s     = 0;
            m_t     = 0;
            m_k     = 0;
            m_live  = 1'b1;
        end else if (m_live) begin
            tk  = (m_phase == N - 1);
            rdy = (q.size() < DEPTH);
            if (tk) begin
                m_s = m_t;
                if (q.size() > 0) m_t = q.pop_front();
                m_k = 0;
            end else begin
                m_k++;
            end
            if (in_valid && rdy) q.push_back(int'(in_data));
            m_phase = (m_phase + 1) % N;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            chk("model_sample_out", int'(sample_out), exp_sample());
            chk("model_tick", int'(tick), (m_phase == N - 1) ? 1 : 0);
            chk("model_underrun", int'(underrun), (m_phase == N - 1 && q.size() == 0) ? 1 : 0);
            chk("model_in_ready", int'(in_ready), (q.size() < DEPTH) ? 1 : 0);
            chk("model_fifo_level", int'(fifo_level), q.size());
        end
    end

    task automatic do_reset(input int cycles);
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_tick(input string name);
        int n = 0;
        while (tick !== 1'b1 && n < 2 * N) begin
            @(negedge clk);
            n++;
        end
        chk(name, int'(tick), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cnt;
        int p;

        @(negedge clk);
        do_reset(3);
        chk("reset_level", int'(fifo_level), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_sample", int'(sample_out), 0);

        // Ramp sequence 0 -> 100 -> 100 -> 0 -> 3 -> 1, then underrun hold.
        idx = 0;
        for (int i = 0; i < 25; i++) begin
            chk("ramp_literal", int'(sample_out), exp1[i]);
            chk("ramp_underrun", int'(underrun), (i == 23) ? 1 : 0);
            if (idx < 5 && in_ready) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(vals1[idx]);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;

        // Single sample then starvation: output must park at 200.
        in_valid = 1'b1;
        in_data  = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3 * N) @(negedge clk);
        cnt = 0;
        for (int i = 0; i < 2 * N; i++) begin
            chk("hold_200", int'(sample_out), 200);
            if (underrun) cnt++;
            @(negedge clk);
        end
        chk("underrun_pulses", cnt, 2);

        // Backpressure with valid held high.
        in_valid = 1'b1;
        for (int i = 0; i < 3 * N; i++) begin
            in_data = WIDTH'($urandom_range(0, 255));
            @(negedge clk);
        end
        wait_tick("bp_wait_tick");
        chk("bp_full_level", int'(fifo_level), 4);
        chk("bp_full_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("bp_after_pop_level", int'(fifo_level), 3);
        chk("bp_after_pop_ready", int'(in_ready), 1);
        @(negedge clk);
        chk("bp_refill_level", int'(fifo_level), 4);
        chk("bp_refill_ready", int'(in_ready), 0);
        in_valid = 1'b0;

        // Push exactly on a tick that finds the FIFO empty.
        cnt = 0;
        while (fifo_level != 0 && cnt < 8 * N) begin
            @(negedge clk);
            cnt++;
        end
        chk("drain_level", int'(fifo_level), 0);
        wait_tick("col_wait_tick");
        chk("col_underrun", int'(underrun), 1);
        in_valid = 1'b1;
        in_data  = 8'd77;
        @(negedge clk);
        in_valid = 1'b0;
        chk("col_level_after", int'(fifo_level), 1);
        chk("col_no_underrun", int'(underrun), 0);
        wait_tick("col_wait_tick2");
        chk("col_level_at_tick", int'(fifo_level), 1);
        @(negedge clk);
        chk("col_consumed", int'(fifo_level), 0);
        repeat (N) @(negedge clk);
        chk("col_target", int'(sample_out), 77);

        // Reset in the middle of a 0 -> 255 ramp with three samples queued.
        do_reset(2);
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            if (idx < 4 && in_ready) begin
                in_valid = 1'b1;
                in_data  = WIDTH'(vals5[idx]);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("midramp_sample", int'(sample_out), 127);
        chk("midramp_level", int'(fifo_level), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_sample", int'(sample_out), 0);
        chk("rst_mid_level", int'(fifo_level), 0);
        chk("rst_mid_ready", int'(in_ready), 1);
        chk("rst_mid_tick", int'(tick), 0);
        cnt = 0;
        while (tick !== 1'b1 && cnt < 2 * N) begin
            @(negedge clk);
            cnt++;
        end
        chk("phase_restart", cnt, N - 1);

        // Randomized traffic with varying load and occasional resets.
        p = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) p = $urandom_range(5, 95);
            if ($urandom_range(0, 499) == 0) begin
                reset    = 1'b1;
                in_valid = 1'b0;
            end else begin
                reset    = 1'b0;
                in_valid = ($urandom_range(0, 99) < p);
                in_data  = WIDTH'($urandom_range(0, 255));
            end
            @(negedge clk);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
